// File: rtl/data_stack_pkg.sv
// data_stack_pkg: stack operation encoding, decoded from {push, pop, load_stk}.
package data_stack_pkg;
   typedef enum logic [2:0] {
      STK_HOLD    = 3'b000,
      STK_REPLACE = 3'b001,
      STK_DROP    = 3'b010,
      STK_BINOP   = 3'b011,
      STK_DUP     = 3'b100,
      STK_PUSH    = 3'b101,
      STK_PP      = 3'b110,
      STK_PPL     = 3'b111
   } stk_op_e;
endpackage

// File: rtl/stack_ram.sv
// stack_ram: spill array with one synchronous write port and one asynchronous read port.
module stack_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   always_ff @(posedge clk)
      if (we) r_mem[waddr] <= wdata;
   assign rdata = r_mem[raddr];
endmodule

// File: rtl/data_stack.sv
// data_stack: two-register top-of-stack with spill array, sticky overflow/underflow flags.
module data_stack
   import data_stack_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   localparam int DW = $clog2(DEPTH + 3),
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             load_stk,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] stk0,
   output logic [WIDTH-1:0] stk1,
   output logic [DW-1:0]    depth,
   output logic             overflow,
   output logic             underflow
);
   logic [WIDTH-1:0] r_stk0, r_stk1;
   logic [DW-1:0]    r_depth;
   logic             r_ovf, r_udf;
   stk_op_e          w_op;
   logic             w_full, w_empty, w_we;
   logic [DW-1:0]    w_spill;
   logic [AW-1:0]    w_waddr, w_raddr;
   logic [WIDTH-1:0] w_rdata, w_top;
   assign w_op    = stk_op_e'({push, pop, load_stk});
   assign w_full  = r_depth == DW'(DEPTH + 2);
   assign w_empty = r_depth == '0;
   assign w_spill = (r_depth >= DW'(2)) ? r_depth - DW'(2) : '0;
   assign w_waddr = w_spill[AW-1:0];
   assign w_raddr = w_waddr - AW'(1);
   // Only spill stk1 once both top registers are occupied.
   assign w_we    = push && !pop && !w_full && (r_depth >= DW'(2));
   assign w_top   = (w_spill != '0) ? w_rdata : '0;
   stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (r_stk1),
      .raddr (w_raddr),
      .rdata (w_rdata)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stk0  <= '0;
         r_stk1  <= '0;
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         case (w_op)
            STK_REPLACE: begin
               r_stk0 <= data_in;
               if (w_empty) r_depth <= DW'(1);
            end
            STK_DUP, STK_PUSH:
               if (w_full) r_ovf <= 1'b1;
               else begin
                  r_stk1  <= r_stk0;
                  r_stk0  <= load_stk ? data_in : r_stk0;
                  r_depth <= r_depth + DW'(1);
               end
            STK_DROP, STK_BINOP:
               if (w_empty) r_udf <= 1'b1;
               else begin
                  r_stk0  <= load_stk ? data_in : r_stk1;
                  r_stk1  <= w_top;
                  r_depth <= r_depth - DW'(1);
               end
            STK_PP, STK_PPL:
               if (load_stk) r_stk0 <= data_in;
            default: ;
         endcase
      end
   end
   assign stk0      = r_stk0;
   assign stk1      = r_stk1;
   assign depth     = r_depth;
   assign overflow  = r_ovf;
   assign underflow = r_udf;
endmodule
